// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 serial pattern detector: state encoding and width.
package seq_det_pkg;

    localparam int SEQ_ST_W = 3;

    // Encodings 5..7 are illegal; the detector recovers from them to S_IDLE.
    typedef enum logic [SEQ_ST_W-1:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } seq_state_e;

endpackage : seq_det_pkg

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter for match events; holds at all-ones instead of wrapping.
module seq_det_sat_counter
    import seq_det_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Clr,
    input  logic               Inc,
    output logic [COUNT_W-1:0] Count
);

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [COUNT_W-1:0] r_count;
    logic               w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (Clr) begin
            r_count <= '0;
        end else if (Inc && !w_at_max) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign Count = r_count;

endmodule : seq_det_sat_counter

// File: rtl/seq_detector_1011.sv
// Serial 1011 detector (MSB first) with registered one-cycle Detect pulse and saturating match count.
module seq_detector_1011
    import seq_det_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Din,
    input  logic               Din_valid,
    input  logic               Clr,
    output logic               Detect,
    output logic [COUNT_W-1:0] Match_count,
    output logic [2:0]         State
);

    // Where a trailing 0 after a full match lands: reuse "10" when overlapping, else start over.
    localparam seq_state_e TAIL0_NEXT = (OVERLAP != 0) ? S_10 : S_IDLE;

    seq_state_e r_state;
    seq_state_e w_state_next;
    logic       r_detect;
    logic       w_detect_next;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_detect <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_detect <= w_detect_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_detect_next = 1'b0;
        if (Clr) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (Din_valid) w_state_next = Din ? S_1    : S_IDLE;
                S_1:    if (Din_valid) w_state_next = Din ? S_1    : S_10;
                S_10:   if (Din_valid) w_state_next = Din ? S_101  : S_IDLE;
                S_101:  if (Din_valid) w_state_next = Din ? S_1011 : S_10;
                S_1011: if (Din_valid) w_state_next = Din ? S_1    : TAIL0_NEXT;
                default: w_state_next = S_IDLE;
            endcase
            // Pulse only on an accepted bit entering S_1011, never while sitting in it.
            w_detect_next = Din_valid && (w_state_next == S_1011);
        end
    end

    seq_det_sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_match_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (Clr),
        .Inc   (w_detect_next),
        .Count (Match_count)
    );

    assign Detect = r_detect;
    assign State  = r_state;

endmodule : seq_detector_1011

// File: tb/tb_seq_detector_1011.sv
// Directed bench: three detector configurations share one stimulus and are checked via a scoreboard.
module tb_seq_detector_1011;
    import seq_det_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst, Din, Din_valid, Clr;
    logic       det_ov, det_no, det_c2;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_c2;
    logic [2:0] st_ov, st_no, st_c2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    seq_detector_1011 #(.OVERLAP(1), .COUNT_W(8)) dut_ov (
        .Clk(Clk), .Rst(Rst), .Din(Din), .Din_valid(Din_valid), .Clr(Clr),
        .Detect(det_ov), .Match_count(cnt_ov), .State(st_ov));
    seq_detector_1011 #(.OVERLAP(0), .COUNT_W(8)) dut_no (
        .Clk(Clk), .Rst(Rst), .Din(Din), .Din_valid(Din_valid), .Clr(Clr),
        .Detect(det_no), .Match_count(cnt_no), .State(st_no));
    seq_detector_1011 #(.OVERLAP(1), .COUNT_W(2)) dut_c2 (
        .Clk(Clk), .Rst(Rst), .Din(Din), .Din_valid(Din_valid), .Clr(Clr),
        .Detect(det_c2), .Match_count(cnt_c2), .State(st_c2));

    typedef struct packed {
        logic [2:0] st;
        logic       det;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   m_st[3];
    int   m_cnt[3];
    int   m_max[3] = '{255, 255, 3};
    bit   m_ov[3]  = '{1'b1, 1'b0, 1'b1};

    function automatic int model_next(int st, bit d, bit ov);
        case (st)
            0: return d ? 1 : 0;
            1: return d ? 1 : 2;
            2: return d ? 3 : 0;
            3: return d ? 4 : 2;
            4: return d ? 1 : (ov ? 2 : 0);
            default: return 0;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            m_st[i]  = 0;
            m_cnt[i] = 0;
            e.st = 3'd0; e.det = 1'b0; e.cnt = 8'd0;
            sb_q.push_back(e);
        end
    endtask

    task automatic model_push(bit d, bit v, bit c);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            bit   det = 1'b0;
            if (c) begin
                m_st[i] = 0; m_cnt[i] = 0;
            end else if (m_st[i] > 4) begin
                m_st[i] = 0;
            end else if (v) begin
                m_st[i] = model_next(m_st[i], d, m_ov[i]);
                det = (m_st[i] == 4);
                if (det && m_cnt[i] < m_max[i]) m_cnt[i]++;
            end
            e.st = 3'(m_st[i]); e.det = det; e.cnt = 8'(m_cnt[i]);
            sb_q.push_back(e);
        end
    endtask

    task automatic compare_all(string tag);
        exp_t e;
        if (sb_q.size() < 3) begin
            n_tests++; n_fail++;
            $display("FAIL %s scoreboard_underflow observed=%0d expected=3", tag, sb_q.size());
            return;
        end
        e = sb_q.pop_front();
        check({tag, "/ov_st"}, 32'(st_ov), 32'(e.st));
        check({tag, "/ov_det"}, 32'(det_ov), 32'(e.det));
        check({tag, "/ov_cnt"}, 32'(cnt_ov), 32'(e.cnt));
        e = sb_q.pop_front();
        check({tag, "/no_st"}, 32'(st_no), 32'(e.st));
        check({tag, "/no_det"}, 32'(det_no), 32'(e.det));
        check({tag, "/no_cnt"}, 32'(cnt_no), 32'(e.cnt));
        e = sb_q.pop_front();
        check({tag, "/c2_st"}, 32'(st_c2), 32'(e.st));
        check({tag, "/c2_det"}, 32'(det_c2), 32'(e.det));
        check({tag, "/c2_cnt"}, 32'(cnt_c2), 32'(e.cnt));
        $display("[TB] %s din=%0b vld=%0b clr=%0b | ov st=%0d det=%0b cnt=%0d | no st=%0d det=%0b cnt=%0d | c2 st=%0d det=%0b cnt=%0d",
                 tag, Din, Din_valid, Clr, st_ov, det_ov, cnt_ov, st_no, det_no, cnt_no, st_c2, det_c2, cnt_c2);
    endtask

    task automatic step(bit d, bit v, bit c, string tag);
        Din = d; Din_valid = v; Clr = c;
        model_push(d, v, c);
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset_pulse();
        Din_valid = 1'b0;
        #2 Rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        #1 Rst = 1'b0;
    endtask

    logic [6:0] stream_a;
    logic [3:0] pat;

    initial begin
        Rst = 1'b1; Din = 1'b0; Din_valid = 1'b0; Clr = 1'b0;
        @(posedge Clk);
        #1;
        model_reset();
        compare_all("reset");
        Rst = 1'b0;

        // Overlap vs non-overlap on 1011011
        stream_a = 7'b1011011;
        for (int i = 6; i >= 0; i--) step(stream_a[i], 1'b1, 1'b0, "streamA");
        check("A_ov_count", 32'(cnt_ov), 32'd2);
        check("A_no_count", 32'(cnt_no), 32'd1);
        check("A_no_state", 32'(st_no), 32'd1);

        // Valid gaps between pattern bits
        step(1'b0, 1'b1, 1'b1, "clr");
        pat = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b0, "gapbit");
            if (i != 0) for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 1'b0, "gap");
        end
        check("gap_ov_count", 32'(cnt_ov), 32'd1);

        // Saturation: 1011 then 011 x4
        step(1'b0, 1'b1, 1'b1, "clr");
        for (int i = 3; i >= 0; i--) step(pat[i], 1'b1, 1'b0, "sat");
        for (int r = 0; r < 4; r++)
            for (int i = 2; i >= 0; i--) step(pat[i], 1'b1, 1'b0, "sat");
        check("sat_c2_count", 32'(cnt_c2), 32'd3);
        check("sat_ov_count", 32'(cnt_ov), 32'd5);

        // Async reset drops a partial prefix
        step(1'b1, 1'b1, 1'b0, "pre_rst");
        step(1'b0, 1'b1, 1'b0, "pre_rst");
        step(1'b1, 1'b1, 1'b0, "pre_rst");
        async_reset_pulse();
        step(1'b1, 1'b1, 1'b0, "post_rst");
        check("rst_state", 32'(st_ov), 32'd1);
        check("rst_count", 32'(cnt_ov), 32'd0);

        // Clr drops a partial prefix and discards its own bit
        step(1'b1, 1'b1, 1'b0, "pre_clr");
        step(1'b0, 1'b1, 1'b0, "pre_clr");
        step(1'b1, 1'b1, 1'b0, "pre_clr");
        step(1'b1, 1'b1, 1'b1, "clr_bit");
        step(1'b1, 1'b1, 1'b0, "post_clr");
        check("clr_state", 32'(st_ov), 32'd1);
        check("clr_det", 32'(det_ov), 32'd0);

        // Illegal state recovery
        step(1'b0, 1'b0, 1'b1, "clr");
        force dut_ov.r_state = seq_state_e'(3'd6);
        #1 release dut_ov.r_state;
        m_st[0] = 6;
        step(1'b0, 1'b1, 1'b0, "illegal");
        check("illegal_state", 32'(st_ov), 32'd0);
        check("illegal_det", 32'(det_ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_detector_1011
